// File: rtl/hazard_ctrl_pkg.sv
// riscv_pkg: shared definitions for the pipeline sequencing controller.
//   hz_state_t  - controller FSM states
//   FWD_*       - EX-stage operand forwarding selects
//   RESULT_LOAD - EX result-select encoding that marks a load
//   max_u()     - elaboration-time helper for sizing counters
package riscv_pkg;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_ERR  = 2'd3
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle of the stage observations the controller reads and
// the pipeline controls it drives.
//   master - datapath side: drives stage addresses/control bits, memory
//            handshake; receives stall/flush/hold/forward controls
//   slave  - hazard_ctrl side
interface hazard_ctrl_if #(
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] i_rs1_addr_d;
  logic [ADDR_WIDTH-1:0] i_rs2_addr_d;
  logic [ADDR_WIDTH-1:0] i_rs1_addr_e;
  logic [ADDR_WIDTH-1:0] i_rs2_addr_e;
  logic [ADDR_WIDTH-1:0] i_rd_addr_e;
  logic [1:0]            i_resultsrc_e;
  logic                  i_pcsrc_e;
  logic [ADDR_WIDTH-1:0] i_rd_addr_m;
  logic                  i_regwrite_m;
  logic [ADDR_WIDTH-1:0] i_rd_addr_w;
  logic                  i_regwrite_w;
  logic                  i_mem_req_m;
  logic                  i_mem_ack;

  logic                  o_stall_f;
  logic                  o_stall_d;
  logic                  o_flush_d;
  logic                  o_flush_e;
  logic                  o_hold_emw;
  logic [1:0]            o_fwd_a_e;
  logic [1:0]            o_fwd_b_e;
  logic                  o_mem_err;

  modport master (
    output i_rs1_addr_d, i_rs2_addr_d, i_rs1_addr_e, i_rs2_addr_e,
           i_rd_addr_e, i_resultsrc_e, i_pcsrc_e, i_rd_addr_m, i_regwrite_m,
           i_rd_addr_w, i_regwrite_w, i_mem_req_m, i_mem_ack,
    input  o_stall_f, o_stall_d, o_flush_d, o_flush_e, o_hold_emw,
           o_fwd_a_e, o_fwd_b_e, o_mem_err
  );

  modport slave (
    input  i_rs1_addr_d, i_rs2_addr_d, i_rs1_addr_e, i_rs2_addr_e,
           i_rd_addr_e, i_resultsrc_e, i_pcsrc_e, i_rd_addr_m, i_regwrite_m,
           i_rd_addr_w, i_regwrite_w, i_mem_req_m, i_mem_ack,
    output o_stall_f, o_stall_d, o_flush_d, o_flush_e, o_hold_emw,
           o_fwd_a_e, o_fwd_b_e, o_mem_err
  );
endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// fwd_unit: combinational EX-stage operand forwarding selects.
//   en                  - forwarding allowed (controller running)
//   rs1_e, rs2_e        - EX source registers
//   rd_m, regwrite_m    - MEM-stage writer
//   rd_w, regwrite_w    - WB-stage writer
//   fwd_a, fwd_b        - FWD_MEM / FWD_WB / FWD_RF select per operand
module fwd_unit
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] rs1_e,
  input  logic [ADDR_WIDTH-1:0] rs2_e,
  input  logic [ADDR_WIDTH-1:0] rd_m,
  input  logic                  regwrite_m,
  input  logic [ADDR_WIDTH-1:0] rd_w,
  input  logic                  regwrite_w,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b
);

  // MEM holds the younger write, so it wins over WB; x0 is never forwarded.
  function automatic logic [1:0] sel(input logic [ADDR_WIDTH-1:0] rs);
    if (regwrite_m && (rd_m != '0) && (rd_m == rs)) return FWD_MEM;
    if (regwrite_w && (rd_w != '0) && (rd_w == rs)) return FWD_WB;
    return FWD_RF;
  endfunction

  assign fwd_a = en ? sel(rs1_e) : FWD_RF;
  assign fwd_b = en ? sel(rs2_e) : FWD_RF;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage RV32I core.
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   bus (slave)    - stage register addresses/control bits and memory
//                    handshake in; stall/flush/hold/forward controls and the
//                    sticky memory-timeout error out
// After reset the pipeline is flushed for RST_FLUSH_CYCLES cycles. A data
// memory access without ack freezes the back end; MEM_TIMEOUT consecutive
// wait cycles without ack lock the controller in S_ERR until reset.
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH       = 5,
  parameter int RST_FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT      = 255
) (
  input logic          i_clk,
  input logic          i_rst_n,
  hazard_ctrl_if.slave bus
);

  localparam int CNT_MAX = int'(max_u(RST_FLUSH_CYCLES, MEM_TIMEOUT));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(RST_FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT);

  hz_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             mem_err;

  logic mem_wait, load_use, fwd_en;
  logic stall_f, stall_d, flush_d, flush_e, hold_emw;

  assign mem_wait = bus.i_mem_req_m & ~bus.i_mem_ack;
  assign load_use = (bus.i_resultsrc_e == RESULT_LOAD) && (bus.i_rd_addr_e != '0) &&
                    ((bus.i_rd_addr_e == bus.i_rs1_addr_d) ||
                     (bus.i_rd_addr_e == bus.i_rs2_addr_d));
  assign fwd_en   = (state == S_RUN) || (state == S_WAIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_INIT;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      mem_err <= (state_nxt == S_ERR);
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    hold_emw  = 1'b0;

    unique case (state)
      S_INIT: begin
        stall_f = 1'b1;
        flush_d = 1'b1;
        flush_e = 1'b1;
        if (cnt == INIT_LAST) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      S_RUN, S_WAIT: begin
        if (mem_wait) begin
          // Freeze the back end; EX contents are stale-held, so load-use and
          // branch decisions are deferred until the access completes.
          hold_emw = 1'b1;
          stall_f  = 1'b1;
          stall_d  = 1'b1;
          if (state == S_RUN) begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_W'(1);
          end else if (cnt == WAIT_LAST) begin
            state_nxt = S_ERR;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end else begin
          // The ack cycle (or any non-waiting cycle) behaves as plain RUN.
          state_nxt = S_RUN;
          cnt_nxt   = '0;
          if (bus.i_pcsrc_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
          end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
        end
      end

      S_ERR: begin
        hold_emw = 1'b1;
        stall_f  = 1'b1;
        stall_d  = 1'b1;
      end

      default: state_nxt = S_INIT;
    endcase
  end

  fwd_unit #(.ADDR_WIDTH(ADDR_WIDTH)) u_fwd (
    .en         (fwd_en),
    .rs1_e      (bus.i_rs1_addr_e),
    .rs2_e      (bus.i_rs2_addr_e),
    .rd_m       (bus.i_rd_addr_m),
    .regwrite_m (bus.i_regwrite_m),
    .rd_w       (bus.i_rd_addr_w),
    .regwrite_w (bus.i_regwrite_w),
    .fwd_a      (bus.o_fwd_a_e),
    .fwd_b      (bus.o_fwd_b_e)
  );

  assign bus.o_stall_f  = stall_f;
  assign bus.o_stall_d  = stall_d;
  assign bus.o_flush_d  = flush_d;
  assign bus.o_flush_e  = flush_e;
  assign bus.o_hold_emw = hold_emw;
  assign bus.o_mem_err  = mem_err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed plus randomized bench for hazard_ctrl, configured
// with MEM_TIMEOUT=4 so the timeout path is reachable. A behavioural model
// tracks "cycles since reset", "consecutive waiting cycles" and an error flag
// and derives every expected control from the pipeline rules.
module tb_hazard_ctrl;

  localparam int AW       = 5;
  localparam int RST_FLSH = 2;
  localparam int TIMEOUT  = 4;

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  // Model state
  int init_cnt;
  int waited;
  bit err;

  hazard_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  hazard_ctrl #(
    .ADDR_WIDTH       (AW),
    .RST_FLUSH_CYCLES (RST_FLSH),
    .MEM_TIMEOUT      (TIMEOUT)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  function automatic bit in_init();
    return init_cnt < RST_FLSH;
  endfunction

  function automatic bit mw_now();
    return bus.i_mem_req_m && !bus.i_mem_ack;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [AW-1:0] rs);
    if (!rst_n || in_init() || err) return 2'b00;
    if (bus.i_regwrite_m && bus.i_rd_addr_m != 0 && bus.i_rd_addr_m == rs) return 2'b10;
    if (bus.i_regwrite_w && bus.i_rd_addr_w != 0 && bus.i_rd_addr_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check_all(input string tag);
    bit e_sf, e_sd, e_fd, e_fe, e_h, e_err;
    bit lu;
    {e_sf, e_sd, e_fd, e_fe, e_h, e_err} = '0;
    lu = bus.i_resultsrc_e == 2'b01 && bus.i_rd_addr_e != 0 &&
         (bus.i_rd_addr_e == bus.i_rs1_addr_d || bus.i_rd_addr_e == bus.i_rs2_addr_d);
    if (!rst_n || in_init()) begin
      e_sf = 1; e_fd = 1; e_fe = 1;
    end else if (err) begin
      e_h = 1; e_sf = 1; e_sd = 1; e_err = 1;
    end else if (mw_now()) begin
      e_h = 1; e_sf = 1; e_sd = 1;
    end else if (bus.i_pcsrc_e) begin
      e_fd = 1; e_fe = 1;
    end else if (lu) begin
      e_sf = 1; e_sd = 1; e_fe = 1;
    end
    check({tag, ".stall_f"},  {1'b0, bus.o_stall_f},  {1'b0, e_sf});
    check({tag, ".stall_d"},  {1'b0, bus.o_stall_d},  {1'b0, e_sd});
    check({tag, ".flush_d"},  {1'b0, bus.o_flush_d},  {1'b0, e_fd});
    check({tag, ".flush_e"},  {1'b0, bus.o_flush_e},  {1'b0, e_fe});
    check({tag, ".hold_emw"}, {1'b0, bus.o_hold_emw}, {1'b0, e_h});
    check({tag, ".mem_err"},  {1'b0, bus.o_mem_err},  {1'b0, e_err});
    check({tag, ".fwd_a"},    bus.o_fwd_a_e, exp_fwd(bus.i_rs1_addr_e));
    check({tag, ".fwd_b"},    bus.o_fwd_b_e, exp_fwd(bus.i_rs2_addr_e));
  endtask

  task automatic model_reset();
    init_cnt = 0;
    waited   = 0;
    err      = 0;
  endtask

  // Advance one clock: model absorbs this cycle's inputs at the edge, then
  // the bench returns to the falling edge to drive the next cycle.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (in_init()) init_cnt++;
    else if (!err) begin
      if (mw_now()) begin
        waited++;
        if (waited > TIMEOUT) err = 1;
      end else begin
        waited = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.i_rs1_addr_d  = '0;
    bus.i_rs2_addr_d  = '0;
    bus.i_rs1_addr_e  = '0;
    bus.i_rs2_addr_e  = '0;
    bus.i_rd_addr_e   = '0;
    bus.i_resultsrc_e = '0;
    bus.i_pcsrc_e     = 1'b0;
    bus.i_rd_addr_m   = '0;
    bus.i_regwrite_m  = 1'b0;
    bus.i_rd_addr_w   = '0;
    bus.i_regwrite_w  = 1'b0;
    bus.i_mem_req_m   = 1'b0;
    bus.i_mem_ack     = 1'b0;
  endtask

  // Assert reset mid-cycle, confirm INIT outputs appear without a clock,
  // then release on the next falling edge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, ".async_stall_f"}, {1'b0, bus.o_stall_f},  2'b01);
    check({tag, ".async_flush_d"}, {1'b0, bus.o_flush_d},  2'b01);
    check({tag, ".async_flush_e"}, {1'b0, bus.o_flush_e},  2'b01);
    check({tag, ".async_hold"},    {1'b0, bus.o_hold_emw}, 2'b00);
    check({tag, ".async_err"},     {1'b0, bus.o_mem_err},  2'b00);
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_all("reset");

    // Reset release: two INIT cycles then RUN with all controls low.
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_all("init_c1");
    check("init_c1.stall_f", {1'b0, bus.o_stall_f}, 2'b01);
    tick();
    #1 check_all("init_c2");
    check("init_c2.flush_e", {1'b0, bus.o_flush_e}, 2'b01);
    tick();
    #1 check_all("run_c3");
    check("run_c3.stall_f", {1'b0, bus.o_stall_f}, 2'b00);
    check("run_c3.flush_d", {1'b0, bus.o_flush_d}, 2'b00);

    // Forwarding priority.
    bus.i_rs1_addr_e = 5'd5; bus.i_rd_addr_m = 5'd5; bus.i_regwrite_m = 1'b1;
    bus.i_rd_addr_w  = 5'd5; bus.i_regwrite_w = 1'b1;
    #1 check_all("fwd_mem");
    check("fwd_mem.a", bus.o_fwd_a_e, 2'b10);
    tick();
    bus.i_regwrite_m = 1'b0;
    #1 check_all("fwd_wb");
    check("fwd_wb.a", bus.o_fwd_a_e, 2'b01);
    tick();
    bus.i_rs1_addr_e = 5'd0; bus.i_rd_addr_m = 5'd0; bus.i_regwrite_m = 1'b1;
    bus.i_rs2_addr_e = 5'd7; bus.i_rd_addr_w = 5'd7;
    #1 check_all("fwd_x0");
    check("fwd_x0.a", bus.o_fwd_a_e, 2'b00);
    check("fwd_x0.b", bus.o_fwd_b_e, 2'b01);
    tick();
    clear_inputs();

    // Load-use, then branch overriding it.
    bus.i_resultsrc_e = 2'b01; bus.i_rd_addr_e = 5'd3; bus.i_rs2_addr_d = 5'd3;
    #1 check_all("load_use");
    check("load_use.stall_d", {1'b0, bus.o_stall_d}, 2'b01);
    check("load_use.flush_e", {1'b0, bus.o_flush_e}, 2'b01);
    tick();
    bus.i_pcsrc_e = 1'b1;
    #1 check_all("lu_branch");
    check("lu_branch.stall_f", {1'b0, bus.o_stall_f}, 2'b00);
    check("lu_branch.flush_d", {1'b0, bus.o_flush_d}, 2'b01);
    tick();
    clear_inputs();

    // Memory wait: three held cycles, release combinationally on ack.
    bus.i_mem_req_m = 1'b1;
    bus.i_pcsrc_e   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check_all("mem_wait");
      check("mem_wait.hold", {1'b0, bus.o_hold_emw}, 2'b01);
      check("mem_wait.flush_d", {1'b0, bus.o_flush_d}, 2'b00);
      tick();
    end
    bus.i_mem_ack = 1'b1;
    bus.i_pcsrc_e = 1'b0;
    #1 check_all("mem_ack");
    check("mem_ack.hold", {1'b0, bus.o_hold_emw}, 2'b00);
    tick();
    clear_inputs();

    // Zero-wait access never holds.
    bus.i_mem_req_m = 1'b1; bus.i_mem_ack = 1'b1;
    #1 check_all("zero_wait");
    tick();
    clear_inputs();
    #1 check_all("zero_wait_after");
    tick();

    // Timeout: error after the fifth edge of an unacked access.
    bus.i_mem_req_m = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 check_all("timeout_wait");
      check("timeout_wait.err", {1'b0, bus.o_mem_err}, 2'b00);
      tick();
    end
    #1 check_all("timeout_err");
    check("timeout_err.err", {1'b0, bus.o_mem_err}, 2'b01);
    check("timeout_err.stall_d", {1'b0, bus.o_stall_d}, 2'b01);
    tick();
    bus.i_mem_ack = 1'b1;
    #1 check_all("err_sticky");
    check("err_sticky.err", {1'b0, bus.o_mem_err}, 2'b01);
    async_reset("err_reset");
    clear_inputs();
    #1 check_all("err_rst_init1");
    tick();
    #1 check_all("err_rst_init2");
    tick();

    // Reset mid-wait: counter restarts, full INIT sequence repeats.
    bus.i_mem_req_m = 1'b1;
    #1 check_all("mid_wait1");
    tick();
    #1 check_all("mid_wait2");
    async_reset("wait_reset");
    #1 check_all("wr_init1");
    check("wr_init1.flush_d", {1'b0, bus.o_flush_d}, 2'b01);
    tick();
    #1 check_all("wr_init2");
    check("wr_init2.flush_d", {1'b0, bus.o_flush_d}, 2'b01);
    tick();
    clear_inputs();
    #1 check_all("wr_run");
    check("wr_run.stall_f", {1'b0, bus.o_stall_f}, 2'b00);
    tick();

    // Randomized traffic; a pending access keeps its request until acked.
    for (int i = 0; i < 400; i++) begin
      bit pending;
      pending = rst_n && !in_init() && !err && waited > 0;
      bus.i_rs1_addr_d  = AW'($urandom_range(0, 3));
      bus.i_rs2_addr_d  = AW'($urandom_range(0, 3));
      bus.i_rs1_addr_e  = AW'($urandom_range(0, 3));
      bus.i_rs2_addr_e  = AW'($urandom_range(0, 3));
      bus.i_rd_addr_e   = AW'($urandom_range(0, 3));
      bus.i_resultsrc_e = 2'($urandom_range(0, 3));
      bus.i_pcsrc_e     = ($urandom_range(0, 3) == 0);
      bus.i_rd_addr_m   = AW'($urandom_range(0, 3));
      bus.i_regwrite_m  = 1'($urandom);
      bus.i_rd_addr_w   = AW'($urandom_range(0, 3));
      bus.i_regwrite_w  = 1'($urandom);
      bus.i_mem_req_m   = pending || ($urandom_range(0, 2) == 0);
      bus.i_mem_ack     = ($urandom_range(0, 3) == 0);
      #1 check_all("rand");
      if (err && $urandom_range(0, 3) == 0) async_reset("rand_reset");
      else tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage RV32I core. Generates per-stage stall, flush and freeze controls plus EX-stage operand-forwarding selects. It also owns the data-memory wait-state handshake with a timeout watchdog and a post-reset pipeline-flush sequence. Sits beside the datapath in `riscv_core`, observing register addresses and control bits from the D/E/M/W stages.

## Interface
- `ADDR_WIDTH`, 5, register address width
- `RST_FLUSH_CYCLES`, 2, cycles of forced flush after reset release (≥1)
- `MEM_TIMEOUT`, 255, max consecutive wait cycles before error (≥1)
- `i_clk` in 1: clock
- `i_rst_n` in 1: reset, asynchronous, active-low
- `i_rs1_addr_d`, `i_rs2_addr_d` in ADDR_WIDTH: source regs in decode
- `i_rs1_addr_e`, `i_rs2_addr_e`, `i_rd_addr_e` in ADDR_WIDTH: regs in execute
- `i_resultsrc_e` in 2: EX result select; 2'b01 = load
- `i_pcsrc_e` in 1: taken branch/jump resolved in EX
- `i_rd_addr_m` in ADDR_WIDTH, `i_regwrite_m` in 1: MEM-stage writer
- `i_rd_addr_w` in ADDR_WIDTH, `i_regwrite_w` in 1: WB-stage writer
- `i_mem_req_m` in 1: MEM stage holds a load/store
- `i_mem_ack` in 1: data memory completes the access this cycle
- `o_stall_f`, `o_stall_d` out 1: hold PC / IF-ID register
- `o_flush_d`, `o_flush_e` out 1: bubble IF-ID / ID-EX register
- `o_hold_emw` out 1: freeze ID-EX, EX-MEM, MEM-WB registers
- `o_fwd_a_e`, `o_fwd_b_e` out 2: 00 regfile, 01 WB result, 10 MEM ALU result
- `o_mem_err` out 1: sticky memory-timeout error

## Operation
- FSM states: S_INIT, S_RUN, S_WAIT, S_ERR. Reset → S_INIT, counter 0, `o_mem_err` 0.
- S_INIT: `o_stall_f`=1, `o_flush_d`=1, `o_flush_e`=1, all other outputs 0. Counter increments each cycle; after RST_FLUSH_CYCLES cycles → S_RUN, counter cleared.
- Forwarding is combinational in S_RUN and S_WAIT; 00 in S_INIT and S_ERR.
  - A: 10 if `i_regwrite_m` & rd_m≠0 & rd_m==rs1_e.
  - Else 01 if `i_regwrite_w` & rd_w≠0 & rd_w==rs1_e.
  - Else 00. MEM has priority over WB.
  - B: same rules using rs2_e.
- Memory wait: `mem_wait` = `i_mem_req_m` & !`i_mem_ack`.
  - In S_RUN or S_WAIT with mem_wait: `o_hold_emw`=1, `o_stall_f`=1, `o_stall_d`=1, both flushes 0.
  - Load-use and branch actions are suppressed while held; EX is frozen, so they re-evaluate after release.
- S_RUN with mem_wait → S_WAIT, counter = 1.
- S_WAIT:
  - ack → S_RUN, counter 0; hold drops combinationally in the ack cycle.
  - No ack: counter increments. When counter == MEM_TIMEOUT → S_ERR.
- S_ERR: `o_mem_err`=1; hold, stall_f and stall_d =1; flushes 0. Left only by reset.
- S_RUN without mem_wait:
  - Load-use = `i_resultsrc_e`==01 & rd_e≠0 & (rd_e==rs1_d | rd_e==rs2_d) → stall_f=1, stall_d=1, flush_e=1.
  - `i_pcsrc_e` → flush_d=1, flush_e=1, stall_f=0, stall_d=0. Branch overrides load-use.
- Counter width: $clog2(max(RST_FLUSH_CYCLES, MEM_TIMEOUT)+1). It must not wrap.

## Timing
- Forwarding, stall, flush and hold outputs are combinational from inputs plus registered state; zero-cycle latency.
- `o_mem_err` is registered: it rises on the edge entering S_ERR.
- The ack cycle is a normal S_RUN cycle: no stall from the memory path.
- A zero-wait access (req & ack same cycle) never enters S_WAIT.
- Asynchronous reset mid-S_WAIT or in S_ERR returns to S_INIT immediately. Outputs take S_INIT values without waiting for a clock.

## Structure
- A shared `riscv_pkg` holds the FSM enum `hz_state_t`, forward-select constants (FWD_RF, FWD_WB, FWD_MEM) and the RESULT_LOAD encoding 2'b01.
- One sub-module, `fwd_unit`, is natural: a purely combinational forwarding mux-select, instantiated once, evaluating both A and B.
- FSM and counter live in `hazard_ctrl`.

## Test plan
- Reset release with default parameters:
  - 2 cycles of stall_f/flush_d/flush_e=1.
  - Cycle 3: all controls 0, state RUN.
- Forwarding priority:
  - rs1_e=5, rd_m=5/regwrite_m=1, rd_w=5/regwrite_w=1 → fwd_a=10.
  - Same with regwrite_m=0 → 01.
  - rd_m=0 → never 10.
- Load-use: resultsrc_e=01, rd_e=3, rs2_d=3 → stall_f=stall_d=flush_e=1 for that cycle.
  - Adding pcsrc_e=1 → stall_f=0, flush_d=flush_e=1.
- Memory wait: req_m=1 held; ack on the 4th cycle → hold_emw=1 for 3 cycles, 0 on the ack cycle, no flushes meanwhile.
- Timeout with MEM_TIMEOUT=4: req_m=1, no ack → o_mem_err=1 after the 5th edge, stalls persist. Reset clears everything and enters S_INIT.
- Reset asserted mid-wait → outputs go to S_INIT values asynchronously; the counter restarts.
